// File: rtl/vend_pkg.sv
// Shared types and coin table for the change dispenser.
// Denominations are ordered largest first so index 0 has the highest priority.
package vend_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_DONE
    } state_t;

    typedef logic [2:0] denom_idx_t;

    localparam int NUM_DENOM = 6;

    localparam logic [15:0] DENOM_VALUE [0:NUM_DENOM-1] = '{
        16'd500, 16'd100, 16'd25, 16'd10, 16'd5, 16'd1
    };

    function automatic logic [15:0] denom_of(input denom_idx_t idx);
        logic [15:0] v;
        case (idx)
            3'd0:    v = 16'd500;
            3'd1:    v = 16'd100;
            3'd2:    v = 16'd25;
            3'd3:    v = 16'd10;
            3'd4:    v = 16'd5;
            3'd5:    v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_coin_select.sv
// Greedy picker: lowest eligible index whose value fits in the remainder.
// Purely combinational; found_o low means nothing can be paid out.
module vend_coin_select
    import vend_pkg::*;
(
    input  logic [15:0]          rem_i,
    input  logic [NUM_DENOM-1:0] elig_i,
    output logic [2:0]           idx_o,
    output logic                 found_o
);

    // Scan high to low so the last hit is the largest coin.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = NUM_DENOM - 1; i >= 0; i--) begin
            if (elig_i[i] && (DENOM_VALUE[i] <= rem_i)) begin
                idx_o   = 3'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change sequencer: one hopper coin per valid/ack handshake, with ack timeout.
// VEND_CHANGE_INVENTORY_EN adds per-coin inventory, refill and short reporting.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1000,
    parameter int TIMER_W     = 10,
    parameter int INV_W       = 8,
    parameter int INV_INIT    = 20
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic             I_REQ_VALID,
    output logic             O_REQ_READY,
    input  logic [15:0]      I_AMOUNT,
    output logic             O_COIN_VALID,
    output logic [2:0]       O_COIN_SEL,
    input  logic             I_COIN_ACK,
    output logic             O_DONE,
    output logic [15:0]      O_REMAIN,
    output logic             O_FAULT,
    output logic             O_SHORT,
    input  logic             I_REFILL,
    input  logic [2:0]       I_REFILL_SEL,
    input  logic [INV_W-1:0] I_REFILL_CNT
);

    state_t               state_q;
    logic [15:0]          rem_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [2:0]           sel_q;
    logic                 ready_q;
    logic                 valid_q;
    logic                 done_q;
    logic                 fault_q;
    logic                 short_q;
    logic [15:0]          remain_q;

    logic [NUM_DENOM-1:0] elig;
    logic [2:0]           pick_idx;
    logic                 pick_found;
    logic                 timeout;

    assign timeout = (timer_q == TIMER_W'(ACK_TIMEOUT - 1));

    vend_coin_select u_pick (
        .rem_i   (rem_q),
        .elig_i  (elig),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

`ifdef VEND_CHANGE_INVENTORY_EN
    logic             ack_take;
    logic [INV_W-1:0] inv_q [NUM_DENOM];
    logic [INV_W-1:0] inv_d [NUM_DENOM];

    assign ack_take = (state_q == S_ISSUE) && I_COIN_ACK;

    // Refill and consume net out; overflow saturates at all-ones.
    for (genvar g = 0; g < NUM_DENOM; g++) begin : g_inv
        logic           add;
        logic           dec;
        logic [INV_W:0] sum;
        assign add = I_REFILL && (I_REFILL_SEL == 3'(g));
        assign dec = ack_take && (sel_q == 3'(g));
        assign sum = {1'b0, inv_q[g]}
                   + (add ? {1'b0, I_REFILL_CNT} : '0)
                   - {{INV_W{1'b0}}, dec};
        assign inv_d[g] = sum[INV_W] ? '1 : sum[INV_W-1:0];
        assign elig[g]  = |inv_q[g];
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                inv_q[i] <= INV_W'(INV_INIT);
            end
        end else begin
            inv_q <= inv_d;
        end
    end

    assign O_SHORT = short_q;
`else
    logic unused_nofeat;

    assign elig          = '1;
    assign O_SHORT       = 1'b0;
    assign unused_nofeat = ^{I_REFILL, I_REFILL_SEL, I_REFILL_CNT, short_q};
`endif

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            timer_q  <= '0;
            sel_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            short_q  <= 1'b0;
            remain_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (I_REQ_VALID) begin
                        rem_q   <= I_AMOUNT;
                        ready_q <= 1'b0;
                        state_q <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (rem_q == 16'd0) begin
                        done_q   <= 1'b1;
                        remain_q <= rem_q;
                        state_q  <= S_DONE;
                    end else if (pick_found) begin
                        sel_q   <= pick_idx;
                        timer_q <= '0;
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end else begin
                        done_q   <= 1'b1;
                        short_q  <= 1'b1;
                        remain_q <= rem_q;
                        state_q  <= S_DONE;
                    end
                end
                S_ISSUE: begin
                    // An ack on the last timer cycle still counts.
                    if (I_COIN_ACK) begin
                        rem_q   <= rem_q - denom_of(sel_q);
                        valid_q <= 1'b0;
                        state_q <= S_SELECT;
                    end else if (timeout) begin
                        valid_q  <= 1'b0;
                        fault_q  <= 1'b1;
                        done_q   <= 1'b1;
                        remain_q <= rem_q;
                        state_q  <= S_DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    short_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign O_REQ_READY  = ready_q;
    assign O_COIN_VALID = valid_q;
    assign O_COIN_SEL   = sel_q;
    assign O_DONE       = done_q;
    assign O_REMAIN     = remain_q;
    assign O_FAULT      = fault_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Scoreboard bench for vend_change_dispenser with a hopper responder model.
// Inventory scenarios run only when VEND_CHANGE_INVENTORY_EN is defined.
module tb_vend_change_dispenser;

    localparam int TB_TIMEOUT  = 8;
    localparam int TB_INV_INIT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        rdy;
    logic [15:0] amount = '0;
    logic        cval;
    logic [2:0]  csel;
    logic        ack = 1'b0;
    logic        done;
    logic [15:0] remain;
    logic        fault;
    logic        shrt;
    logic        refill = 1'b0;
    logic [2:0]  refill_sel = '0;
    logic [7:0]  refill_cnt = '0;

    always #5 clk = ~clk;

    vend_change_dispenser #(
        .ACK_TIMEOUT (TB_TIMEOUT),
        .TIMER_W     (10),
        .INV_W       (8),
        .INV_INIT    (TB_INV_INIT)
    ) dut (
        .I_CLK        (clk),
        .I_RESET      (rst),
        .I_REQ_VALID  (req_valid),
        .O_REQ_READY  (rdy),
        .I_AMOUNT     (amount),
        .O_COIN_VALID (cval),
        .O_COIN_SEL   (csel),
        .I_COIN_ACK   (ack),
        .O_DONE       (done),
        .O_REMAIN     (remain),
        .O_FAULT      (fault),
        .O_SHORT      (shrt),
        .I_REFILL     (refill),
        .I_REFILL_SEL (refill_sel),
        .I_REFILL_CNT (refill_cnt)
    );

    typedef struct {
        int sel;
        int cyc;
    } coin_t;

    typedef struct {
        int remain;
        int fault;
        int shrt;
        int lat;
        int run;
    } done_t;

    coin_t coin_q[$];
    done_t done_q[$];
    coin_t c;
    done_t d;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int run = 0;
    int last_run = 0;
    int done_cnt = 0;
    int vtot = 0;
    int hold_sel = 0;
    int ack_delay = 0;
    int wcnt = 0;
    bit ack_en = 1'b0;
    bit stray_en = 1'b0;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Hopper model drives ack first, then the scoreboard samples.
    always @(negedge clk) begin
        if (rst) begin
            ack  = 1'b0;
            wcnt = 0;
        end else if (cval) begin
            if (!ack_en) begin
                ack = 1'b0;
            end else if (wcnt >= ack_delay) begin
                ack  = 1'b1;
                wcnt = 0;
            end else begin
                ack = 1'b0;
                wcnt++;
            end
        end else begin
            ack  = stray_en;
            wcnt = 0;
        end

        if (rst) begin
            run = 0;
        end else begin
            if (req_valid && rdy) acc_cyc = cyc;
            if (cval) begin
                vtot++;
                run++;
                if (run > 1) check("sel_hold", csel, hold_sel);
                hold_sel = csel;
                if (ack) begin
                    if (coin_q.size() == 0) begin
                        check("coin_unexp", coin_q.size(), 1);
                    end else begin
                        c = coin_q.pop_front();
                        check("coin_sel", csel, c.sel);
                        check("coin_cyc", run, c.cyc);
                    end
                    run = 0;
                end
            end else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    check("done_unexp", done_q.size(), 1);
                end else begin
                    d = done_q.pop_front();
                    check("remain", remain, d.remain);
                    check("fault", fault, d.fault);
                    check("short", shrt, d.shrt);
                    if (d.lat >= 0) check("latency", cyc - acc_cyc, d.lat);
                    if (d.run >= 0) check("fault_run", last_run, d.run);
                end
            end else begin
                if (fault) check("fault_nodone", fault, 0);
                if (shrt) check("short_nodone", shrt, 0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input int amt);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        amount    = 16'(amt);
        req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("req_ready", got, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int start;
        bit got;
        start = done_cnt;
        got   = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            if (done_cnt != start) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", got, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic push_coin(input int sel, input int cycles);
        coin_q.push_back('{sel: sel, cyc: cycles});
    endtask

    task automatic push_done(input int rem, input int f, input int s,
                             input int lat, input int rn);
        done_q.push_back('{remain: rem, fault: f, shrt: s, lat: lat, run: rn});
    endtask

    initial begin
        int v0;
        bit seen;
        int sels[6];

        do_reset();
        @(negedge clk);
        check("rst_ready", rdy, 1);
        check("rst_valid", cval, 0);
        check("rst_sel", csel, 0);
        check("rst_done", done, 0);
        check("rst_remain", remain, 0);
        check("rst_fault", fault, 0);
        check("rst_short", shrt, 0);

        // Zero amount: no coins, done two cycles after accept.
        ack_en    = 1'b1;
        ack_delay = 0;
        v0 = vtot;
        push_done(0, 0, 0, 2, -1);
        send(0);
        wait_done(50);
        check("zero_no_coin", vtot - v0, 0);

        // 641 = 500+100+25+10+5+1, ack on first valid cycle.
        do_reset();
        sels = '{0, 1, 2, 3, 4, 5};
        foreach (sels[i]) push_coin(sels[i], 1);
        push_done(0, 0, 0, -1, -1);
        send(641);
        wait_done(200);

        // 30 = 25+5 with slow hopper and stray acks outside issue.
        do_reset();
        ack_delay = 3;
        stray_en  = 1'b1;
        push_coin(2, 4);
        push_coin(4, 4);
        push_done(0, 0, 0, -1, -1);
        send(30);
        wait_done(200);
        stray_en  = 1'b0;
        ack_delay = 0;

        // Stalled hopper: fault after TB_TIMEOUT valid cycles.
        do_reset();
        ack_en = 1'b0;
        push_done(100, 1, 0, -1, TB_TIMEOUT);
        send(100);
        wait_done(100);
        ack_en = 1'b1;

        // Reset during first issue cycle aborts silently.
        do_reset();
        ack_en = 1'b0;
        send(500);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cval) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_test_valid_seen", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", cval, 0);
        check("midrst_ready", rdy, 1);
        check("midrst_done", done, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        ack_en = 1'b1;

`ifdef VEND_CHANGE_INVENTORY_EN
        // One coin each: 210 pays 100,25,10,5,1 then runs short at 69.
        do_reset();
        sels = '{1, 2, 3, 4, 5, 0};
        for (int i = 0; i < 5; i++) push_coin(sels[i], 1);
        push_done(69, 0, 1, -1, -1);
        send(210);
        wait_done(200);

        @(posedge clk);
        #1;
        refill     = 1'b1;
        refill_sel = 3'd1;
        refill_cnt = 8'd3;
        @(posedge clk);
        #1 refill = 1'b0;

        push_coin(1, 1);
        push_coin(1, 1);
        push_done(0, 0, 0, -1, -1);
        send(200);
        wait_done(200);
`endif

        repeat (5) @(posedge clk);
        check("coin_q_empty", coin_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
